serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller. It accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake. It streams the operands LSB-first through a single 1-bit full-adder cell, with the carry held in a register. It then returns the WIDTH-bit sum and carry-out on a valid/ready output handshake. It sits directly upstream of the 1-bit full-adder cell, sequencing and feeding it and collecting its sum and carry outputs.

Parameters:
WIDTH, 8, operand/sum width in bits (legal range 1..64).
CNT_W, $clog2(WIDTH)+1, bit counter width (derived; not overridden).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands a/b/cin present.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  sum/cout valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  a+b+cin, low WIDTH bits.
cout  output  1  carry-out of bit WIDTH-1.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset values: state=IDLE, in_ready=1 once rst_n deasserts, out_valid=0, sum=0, cout=0, busy=0.
  - Internal shift registers, carry register and bit counter all reset to 0.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from state only; there are no combinational in→out paths.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge E0: latch a→a_sr, b→b_sr, cin→carry_q; clear sum_sr and cnt; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, the cell computes s=a_sr[0]^b_sr[0]^carry_q and co=majority(a_sr[0], b_sr[0], carry_q).
  - At each edge: a_sr and b_sr shift right by 1 (zero fill); sum_sr shifts right with s inserted at bit WIDTH-1; carry_q<=co; cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge: sum<=final sum_sr value (including this bit), cout<=co, out_valid<=1, go to DONE.
- Latency: exactly WIDTH edges after the acceptance edge E0. out_valid is high after edge E0+WIDTH.
- DONE:
  - out_valid=1. sum and cout held stable until the handshake.
  - On out_valid && out_ready: out_valid<=0, go to IDLE. in_ready is reasserted the cycle after the handshake.
  - No accept occurs in the same cycle as the output handshake.
  - Minimum issue interval: WIDTH+2 cycles.
- in_valid is ignored while in_ready=0. The a/b/cin inputs need not be held after the accept edge.
- sum and cout retain the last result after the output handshake until the next completion. Consumers sample only on out_valid.
- Overflow: the result wraps modulo 2^WIDTH, with the overflowing bit reported on cout. 0xFF+0x01 with WIDTH=8 gives sum=0x00, cout=1.
- WIDTH=1: the single RUN cycle completes immediately (cnt==0==WIDTH-1).
- Reset mid-operation (any state): immediate abort to reset values. Partial results are discarded and no out_valid is produced.
- out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Package serial_add_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sa_state_t;
  - the CNT_W derivation function.
- One sub-module, fa_cell:
  - combinational 1-bit full adder (a, b, carry_in → sum, carry_out);
  - instantiated once, and the only place bit arithmetic occurs.

Test Plan:
- 1. WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 → out_valid exactly 8 cycles after accept; sum=0x96, cout=0.
- 2. WIDTH=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- 3. Backpressure: complete a=0x12+b=0x34 and hold out_ready=0 for 5 cycles → sum=0x46 stable, out_valid stays 1, in_ready=0. A pulse of in_valid with a=0x77 during this window is ignored; after release the next result is unaffected.
- 4. Back-to-back: keep in_valid=1 with operand pairs (1,2), (3,4), (0x80,0x80) and out_ready=1 → results 0x03/0, 0x07/0, 0x00/1 in order. Accepts are spaced exactly WIDTH+2=10 cycles apart.
- 5. Reset mid-RUN: accept a=0xAA, b=0x55, pull rst_n low after 3 RUN edges → outputs immediately 0, busy=0. After release: in_ready=1, no stray out_valid, and the next op 0x01+0x01 gives 0x02.
- 6. WIDTH=1 build: a=1, b=1, cin=1 → sum=1, cout=1, out_valid one cycle after accept.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// Holds the FSM state encoding and the bit-counter width derivation.
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } sa_state_t;

  // One extra bit so the counter can represent WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: accepts a/b/cin, ripples them LSB-first through
// one full-adder cell over WIDTH cycles, then presents sum/cout until taken.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output sa_state_t        state
);

  localparam int CNT_W = cnt_width(WIDTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. in_ready/out_valid depend only on state, never on inputs.
  sa_state_t        state_q;
  sa_state_t        state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_shift;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             s_bit;
  logic             co_bit;
  logic             last_bit;

  fa_cell u_fa (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .carry_in  (carry_q),
    .sum       (s_bit),
    .carry_out (co_bit)
  );

  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
  // New bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
  assign sum_shift = (sum_sr >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last_bit)  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            sum_sr  <= '0;
            cnt     <= '0;
          end
        end
        S_RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= sum_shift;
          carry_q <= co_bit;
          cnt     <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= sum_shift;
            cout <= co_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for the main flows
// plus a 1-bit instance for the degenerate width.
module tb_serial_adder_ctrl;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  sa_state_t    state;

  logic         in_valid1;
  logic         in_ready1;
  logic [0:0]   a1;
  logic [0:0]   b1;
  logic         cin1;
  logic         out_valid1;
  logic         out_ready1;
  logic [0:0]   sum1;
  logic         cout1;
  logic         busy1;
  sa_state_t    state1;

  int checks;
  int errors;
  int cyc;
  int n_results;
  int acc_cyc[$];
  logic [W:0] exp_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy), .state(state)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1), .state(state1)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every completed output handshake must match the next expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_results++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {cout, sum}, '1);
      end else begin
        chk("result", {cout, sum}, exp_q.pop_front());
      end
    end
    if (rst_n && in_valid && in_ready) acc_cyc.push_back(cyc);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a = av;
    b = bv;
    cin = cv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_valid1(output int lat);
    lat = 0;
    while (!out_valid1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic [W:0] expv);
    int lat;
    exp_q.push_back(expv);
    send(av, bv, cv);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_sum"}, sum, expv[W-1:0]);
    chk({tag, "_cout"}, cout, expv[W]);
    tick();
    chk({tag, "_in_ready_after"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    int budget;
    bit stray;
    checks = 0;
    errors = 0;
    cyc = 0;
    n_results = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b1;
    in_valid1 = 1'b0;
    a1 = '0;
    b1 = '0;
    cin1 = 1'b0;
    out_ready1 = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", state, S_IDLE);

    // Basic add and overflow cases
    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 9'h096);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // Backpressure with an ignored in_valid pulse
    out_ready = 1'b0;
    exp_q.push_back(9'h046);
    send(8'h12, 8'h34, 1'b0);
    wait_valid(lat);
    chk("bp_latency", lat, W);
    a = 8'h77;
    b = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      in_valid = 1'b0;
      chk("bp_sum_stable", sum, 8'h46);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_released", out_valid, 1'b0);
    run_op("after_bp", 8'h10, 8'h20, 1'b0, 9'h030);

    // Back-to-back issue with in_valid held high
    acc_cyc.delete();
    exp_q.push_back(9'h003);
    exp_q.push_back(9'h007);
    exp_q.push_back(9'h100);
    a = 8'h01;
    b = 8'h02;
    cin = 1'b0;
    in_valid = 1'b1;
    budget = 0;
    while (acc_cyc.size() < 3 && budget < 200) begin
      tick();
      budget++;
      if (acc_cyc.size() == 1) begin
        a = 8'h03;
        b = 8'h04;
      end else if (acc_cyc.size() == 2) begin
        a = 8'h80;
        b = 8'h80;
      end
    end
    in_valid = 1'b0;
    chk("b2b_accept_count", acc_cyc.size(), 3);
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      tick();
      budget++;
    end
    chk("b2b_drained", exp_q.size(), 0);
    if (acc_cyc.size() >= 3) begin
      chk("b2b_gap_1", acc_cyc[1] - acc_cyc[0], W + 2);
      chk("b2b_gap_2", acc_cyc[2] - acc_cyc[1], W + 2);
    end
    tick();

    // Reset in the middle of RUN
    send(8'hAA, 8'h55, 1'b0);
    tick();
    tick();
    tick();
    chk("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_in_ready", in_ready, 1'b1);
    stray = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) stray = 1'b1;
      tick();
    end
    chk("mid_rst_no_stray", stray, 1'b0);
    run_op("after_rst", 8'h01, 8'h01, 1'b0, 9'h002);

    // WIDTH=1 instance
    a1 = 1'b1;
    b1 = 1'b1;
    cin1 = 1'b1;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    wait_valid1(lat);
    chk("w1_latency", lat, 1);
    chk("w1_sum", sum1, 1'b1);
    chk("w1_cout", cout1, 1'b1);
    tick();
    chk("w1_handshake", out_valid1, 1'b0);
    a1 = 1'b0;
    b1 = 1'b1;
    cin1 = 1'b0;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    wait_valid1(lat);
    chk("w1b_latency", lat, 1);
    chk("w1b_sum", sum1, 1'b1);
    chk("w1b_cout", cout1, 1'b0);
    tick();

    // Final report
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("result_count", n_results, 9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
